// File: rtl/popcount_seq_if.sv
// Request/result bundle for the sequential ones-counter.
// The requester drives start/din. The counter returns busy, done, count and majority.
interface popcount_seq_if #(
   parameter int WIDTH = 16
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             start;
   logic [WIDTH-1:0] din;
   logic             busy;
   logic             done;
   logic [CW-1:0]    count;
   logic             majority;

   modport master (
      output start,
      output din,
      input  busy,
      input  done,
      input  count,
      input  majority
   );

   modport slave (
      input  start,
      input  din,
      output busy,
      output done,
      output count,
      output majority
   );
endinterface

// File: rtl/popcount_seq.sv
// Sequential ones-counter and majority engine.
// A WIDTH-bit word is latched on start. Its set bits are summed CHUNK bits per clock.
// The result is published with a one-cycle done pulse.
module popcount_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic                clk,
   input  logic                rst,
   popcount_seq_if.slave       bus
);
   localparam int NSTEP = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int PW    = NSTEP * CHUNK;
   localparam int CW    = $clog2(WIDTH + 1);
   localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_t;

   // Number of set bits in one chunk; CHUNK <= WIDTH so the sum always fits in CW bits.
   function automatic logic [CW-1:0] chunk_ones(input logic [CHUNK-1:0] v);
      logic [CW-1:0] ones;
      ones = {CW{1'b0}};
      for (int i = 0; i < CHUNK; i++) begin
         ones = ones + CW'(v[i]);
      end
      return ones;
   endfunction

   state_t        state_r;
   logic [PW-1:0] shift_r;
   logic [CW-1:0] acc_r;
   logic [SW-1:0] step_r;
   logic          busy_r;
   logic          done_r;
   logic [CW-1:0] count_r;
   logic          majority_r;

   logic [CW-1:0] acc_next_s;
   logic          last_step_s;

   // Running sum including the chunk at the bottom of the shift register, and last-step detect.
   always_comb begin
      acc_next_s  = acc_r + chunk_ones(shift_r[CHUNK-1:0]);
      last_step_s = (step_r == SW'(NSTEP - 1));
   end

   // Control FSM with datapath; every output is a register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         shift_r    <= {PW{1'b0}};
         acc_r      <= {CW{1'b0}};
         step_r     <= {SW{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         count_r    <= {CW{1'b0}};
         majority_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  // The MSB side is zero-padded so the last partial chunk adds nothing extra.
                  shift_r <= PW'(bus.din);
                  acc_r   <= {CW{1'b0}};
                  step_r  <= {SW{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= ST_COUNT;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_COUNT: begin
               acc_r   <= acc_next_s;
               shift_r <= shift_r >> CHUNK;
               step_r  <= step_r + SW'(1);
               if (last_step_s) begin
                  count_r    <= acc_next_s;
                  majority_r <= (acc_next_s > CW'(WIDTH / 2));
                  done_r     <= 1'b1;
                  busy_r     <= 1'b0;
                  state_r    <= ST_IDLE;
               end else begin
                  done_r     <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= ST_COUNT;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.count    = count_r;
   assign bus.majority = majority_r;
endmodule
